pulse_train_gen: RTL and testbench

Programmable pulse-train transmitter. On `start` it emits `cfg_num` pulses on `pulse_out`, each `cfg_high` cycles high and separated by `cfg_low` cycles low, then reports completion. It drives strobe and heartbeat lines that downstream edge detectors and watchdogs sample.

---
 rtl/pulse_train_pkg.sv | 23 ++
 rtl/pulse_train_gen_phase_counter.sv | 42 ++++
 rtl/pulse_train_gen.sv | 162 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// -----------------------------------------------------------------------------
// pulse_train_pkg
// Shared definitions for the pulse-train transmitter.
//   STATE_W        : width of the one-hot FSM state vector
//   IDLE/HIGH/LOW  : one-hot state encodings
//   CNT_W_DEFAULT  : default width of configuration fields and counters
//   cfg_low_eff()  : maps a requested low length of 0 onto 1
// -----------------------------------------------------------------------------
package pulse_train_pkg;

    localparam int STATE_W       = 3;
    localparam int CNT_W_DEFAULT = 8;

    localparam logic [STATE_W-1:0] IDLE = 3'b001;
    localparam logic [STATE_W-1:0] HIGH = 3'b010;
    localparam logic [STATE_W-1:0] LOW  = 3'b100;

    // A zero-length gap would merge adjacent pulses, so it is stretched to one cycle.
    function automatic logic [CNT_W_DEFAULT-1:0] cfg_low_eff8(input logic [CNT_W_DEFAULT-1:0] v);
        return (v == '0) ? CNT_W_DEFAULT'(1) : v;
    endfunction

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Simple CNT_W-bit up counter used for both phase and pulse counting.
//   clk      : system clock
//   rst      : asynchronous active-high reset, clears the count
//   cnt_init : synchronous clear to zero (wins over cnt_incr)
//   cnt_incr : increment by one
//   cnt_val  : current count
// -----------------------------------------------------------------------------
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_init,
    input  logic             cnt_incr,
    output logic [CNT_W-1:0] cnt_val
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_init) begin
            cnt_d = '0;
        end else if (cnt_incr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_val = cnt_q;

endmodule

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// Programmable pulse-train transmitter. A start in IDLE latches the
// configuration and emits cfg_num pulses of cfg_high cycles separated by
// max(cfg_low,1) low cycles, then pulses done for one cycle.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : one-cycle request, honoured only in IDLE
//   halt      : abort to IDLE, highest priority, no done
//   cfg_high  : high-phase length (>=1)
//   cfg_low   : low-phase length (0 treated as 1)
//   cfg_num   : number of pulses (>=1)
//   pulse_out : pulse train, decoded from the state register
//   busy      : train in progress
//   done      : one-cycle pulse after the last high cycle
//   cfg_err   : one-cycle pulse after a start rejected for bad configuration
// -----------------------------------------------------------------------------
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_num,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    logic [STATE_W-1:0] state_q,   state_d;
    logic [CNT_W-1:0]   high_q,    high_d;
    logic [CNT_W-1:0]   low_q,     low_d;
    logic [CNT_W-1:0]   num_q,     num_d;
    logic               done_q,    done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               ph_init, ph_incr;
    logic               pc_init, pc_incr;
    logic [CNT_W-1:0]   phase;
    logic [CNT_W-1:0]   pulse;

    logic               phase_last_high;
    logic               phase_last_low;
    logic               pulse_last;

    phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt_init (ph_init),
        .cnt_incr (ph_incr),
        .cnt_val  (phase)
    );

    phase_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt_init (pc_init),
        .cnt_incr (pc_incr),
        .cnt_val  (pulse)
    );

    // Shadow values are always >=1 while a train runs, so the minus-one
    // terms never wrap and the full 2^CNT_W-1 range is usable.
    assign phase_last_high = (phase == high_q - CNT_W'(1));
    assign phase_last_low  = (phase == low_q  - CNT_W'(1));
    assign pulse_last      = (pulse == num_q  - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        low_d     = low_q;
        num_d     = num_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        ph_init   = 1'b0;
        ph_incr   = 1'b0;
        pc_init   = 1'b0;
        pc_incr   = 1'b0;

        if (halt) begin
            state_d = IDLE;
            ph_init = 1'b1;
            pc_init = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_high == '0 || cfg_num == '0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            high_d  = cfg_high;
                            low_d   = (cfg_low == '0) ? CNT_W'(1) : cfg_low;
                            num_d   = cfg_num;
                            ph_init = 1'b1;
                            pc_init = 1'b1;
                            state_d = HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (phase_last_high) begin
                        ph_init = 1'b1;
                        if (pulse_last) begin
                            // Last pulse: no trailing gap, finish straight away.
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            pc_incr = 1'b1;
                            state_d = LOW;
                        end
                    end else begin
                        ph_incr = 1'b1;
                    end
                end
                LOW: begin
                    if (phase_last_low) begin
                        ph_init = 1'b1;
                        state_d = HIGH;
                    end else begin
                        ph_incr = 1'b1;
                    end
                end
                default: begin
                    // Non-one-hot state: recover to IDLE with clean counters.
                    state_d = IDLE;
                    ph_init = 1'b1;
                    pc_init = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            high_q    <= '0;
            low_q     <= '0;
            num_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            low_q     <= low_d;
            num_q     <= num_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign pulse_out = (state_q == HIGH);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             halt;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [CNT_W-1:0] cfg_num;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks;
    int errors;

    pulse_train_gen #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt      (halt),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .cfg_num   (cfg_num),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0;
        cfg_high = '0; cfg_low = '0; cfg_num = '0;
        step();
        step();
        checks++;
        if ({pulse_out, busy, done, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {pulse_out, busy, done, cfg_err});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({pulse_out, busy, done, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {pulse_out, busy, done, cfg_err});
        end
    endtask

    // Starts a train with the given config and checks every cycle of it plus the done cycle.
    // If disturb is set, start is re-pulsed and the cfg inputs are scrambled mid-train.
    task automatic run_train(input int h, input int l, input int n, input bit disturb, input string name);
        int lp;
        int total;
        int pos;
        logic exp_p;
        lp = (l == 0) ? 1 : l;
        total = n * h + (n - 1) * lp;
        cfg_high = CNT_W'(h); cfg_low = CNT_W'(l); cfg_num = CNT_W'(n);
        start = 1'b1;
        for (int i = 1; i <= total; i++) begin
            step();
            start = 1'b0;
            if (disturb && i == 2) begin
                start = 1'b1;
                cfg_high = 8'd7; cfg_low = 8'd0; cfg_num = 8'd1;
            end
            pos = (i - 1) % (h + lp);
            exp_p = (pos < h);
            checks++;
            if ({pulse_out, busy, done} !== {exp_p, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s cycle %0d: pulse/busy/done got %b expected %b",
                         name, i, {pulse_out, busy, done}, {exp_p, 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL %s done_cycle: pulse/busy/done got %b expected 001", name, {pulse_out, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [12:0] exp_pat;
        exp_pat = 13'b1110011100111;
        cfg_high = 8'd3; cfg_low = 8'd2; cfg_num = 8'd3;
        start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            start = 1'b0;
            checks++;
            if ({pulse_out, busy, done} !== {exp_pat[12 - i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL basic cycle %0d: pulse/busy/done got %b expected %b",
                         i + 1, {pulse_out, busy, done}, {exp_pat[12 - i], 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL basic done_cycle: got %b expected 001", {pulse_out, busy, done});
        end
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL basic after_done: got %b expected 000", {pulse_out, busy, done});
        end
    endtask

    task automatic test_min_low();
        logic [2:0] exp_pat;
        exp_pat = 3'b101;
        cfg_high = 8'd1; cfg_low = 8'd0; cfg_num = 8'd2;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            start = 1'b0;
            checks++;
            if ({pulse_out, busy, done} !== {exp_pat[2 - i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL min_low cycle %0d: got %b expected %b",
                         i + 1, {pulse_out, busy, done}, {exp_pat[2 - i], 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL min_low done_cycle: got %b expected 001", {pulse_out, busy, done});
        end
        step();
    endtask

    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            cfg_high = (k == 0) ? 8'd3 : 8'd0;
            cfg_num  = (k == 0) ? 8'd0 : 8'd3;
            cfg_low  = 8'd1;
            start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if ({cfg_err, pulse_out, busy, done} !== 4'b1000) begin
                errors++;
                $display("FAIL cfg_err_%0d: err/pulse/busy/done got %b expected 1000", k, {cfg_err, pulse_out, busy, done});
            end
            step();
            checks++;
            if ({cfg_err, pulse_out, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL cfg_err_clear_%0d: got %b expected 0000", k, {cfg_err, pulse_out, busy, done});
            end
        end
        // halt together with start in IDLE: nothing starts, no error even for bad cfg
        for (int k = 0; k < 2; k++) begin
            cfg_high = 8'd2; cfg_low = 8'd1;
            cfg_num  = (k == 0) ? 8'd0 : 8'd2;
            start = 1'b1; halt = 1'b1;
            step();
            start = 1'b0; halt = 1'b0;
            checks++;
            if ({cfg_err, pulse_out, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL halt_start_%0d: got %b expected 0000", k, {cfg_err, pulse_out, busy, done});
            end
        end
        step();
    endtask

    task automatic test_halt();
        cfg_high = 8'd4; cfg_low = 8'd4; cfg_num = 8'd5;
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            start = 1'b0;
        end
        // cycle 10 is the second cycle of the second pulse
        checks++;
        if ({pulse_out, busy} !== 2'b11) begin
            errors++;
            $display("FAIL halt_pre: pulse/busy got %b expected 11", {pulse_out, busy});
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL halt_post: pulse/busy/done got %b expected 000", {pulse_out, busy, done});
        end
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL halt_idle: pulse/busy/done got %b expected 000", {pulse_out, busy, done});
        end
        run_train(4, 4, 5, 1'b0, "halt_restart");
        step();
    endtask

    task automatic test_ignore();
        run_train(2, 3, 3, 1'b1, "ignore_midtrain");
        start = 1'b0;
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL ignore_after: got %b expected 000", {pulse_out, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        run_train(2, 1, 2, 1'b0, "b2b_first");
        // start during the done cycle is accepted
        run_train(1, 1, 1, 1'b0, "b2b_second");
        step();
    endtask

    task automatic test_async_rst();
        cfg_high = 8'd5; cfg_low = 8'd1; cfg_num = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pulse_out, busy, done, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst: got %b expected 0000", {pulse_out, busy, done, cfg_err});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_train(255, 0, 1, 1'b0, "max_high");
        step();
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL max_high_after: got %b expected 000", {pulse_out, busy, done});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_min_low();
        test_cfg_err();
        test_halt();
        test_ignore();
        test_back_to_back();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
